// File: rtl/hub75_linebuf_if.sv
// Pixel-stream, read-port and swap handshake bundle for the HUB75 row-pair line buffer.
interface hub75_linebuf_if #(
  parameter int unsigned COLBITS   = 6,
  parameter int unsigned BPC       = 8,
  parameter int unsigned PLANEBITS = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3*BPC-1:0]     in_data;
  logic                 rd_en;
  logic [COLBITS-1:0]   rd_col;
  logic [PLANEBITS-1:0] rd_plane;
  logic [2:0]           rgb1;
  logic [2:0]           rgb2;
  logic                 swap;
  logic                 swap_ack;
  logic                 underrun;
  logic                 front_valid;

  modport master (
    output in_valid, in_data, rd_en, rd_col, rd_plane, swap,
    input  in_ready, rgb1, rgb2, swap_ack, underrun, front_valid
  );

  modport slave (
    input  in_valid, in_data, rd_en, rd_col, rd_plane, swap,
    output in_ready, rgb1, rgb2, swap_ack, underrun, front_valid
  );
endinterface

// File: rtl/hub75_linebuf.sv
// Double-buffered row-pair line buffer: fills the back bank from a pixel stream and
// serves per-column, per-bitplane RGB bits from the front bank with 1-cycle latency.
module hub75_linebuf #(
  parameter int unsigned COLBITS   = 6,
  parameter int unsigned BPC       = 8,
  parameter int unsigned PLANEBITS = 3
) (
  input  logic            clk,
  input  logic            reset,
  hub75_linebuf_if.slave  bus
);
  localparam int unsigned COLS = 2**COLBITS;
  localparam int unsigned PW   = 3*BPC;

  typedef enum logic {FILL, FULL} wstate_t;

  wstate_t          state, state_nxt;
  logic [COLBITS:0] wcnt, wcnt_nxt;
  logic             front, front_nxt;
  logic             front_valid, front_valid_nxt;
  logic             swap_ack, swap_ack_nxt;
  logic             underrun, underrun_nxt;
  logic [2:0]       rgb1, rgb2;
  logic             wr_fire;

  logic [PW-1:0]    mem [4*COLS];
  logic [PW-1:0]    up_px, lo_px;

  // Address layout is {bank, half, column}; writes always target the non-front bank.
  assign up_px = mem[{front, 1'b0, bus.rd_col}];
  assign lo_px = mem[{front, 1'b1, bus.rd_col}];

  assign bus.in_ready    = (state == FILL) && !reset;
  assign wr_fire         = bus.in_valid && bus.in_ready;
  assign bus.rgb1        = rgb1;
  assign bus.rgb2        = rgb2;
  assign bus.swap_ack    = swap_ack;
  assign bus.underrun    = underrun;
  assign bus.front_valid = front_valid;

  function automatic logic [2:0] plane_bits(input logic [PW-1:0] px,
                                            input logic [PLANEBITS-1:0] pl);
    plane_bits = '0;
    for (int unsigned b = 0; b < BPC; b++) begin
      if (32'(pl) == b) plane_bits = {px[2*BPC+b], px[BPC+b], px[b]};
    end
  endfunction

  always_comb begin
    state_nxt       = state;
    wcnt_nxt        = wcnt;
    front_nxt       = front;
    front_valid_nxt = front_valid;
    swap_ack_nxt    = 1'b0;
    underrun_nxt    = 1'b0;
    case (state)
      FILL: begin
        if (wr_fire) begin
          if (&wcnt) begin
            state_nxt = FULL;
            wcnt_nxt  = '0;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      FULL: ;
      default: state_nxt = FILL;
    endcase
    // A swap evaluated against the pre-edge state: a final write in the same cycle still underruns.
    if (bus.swap) begin
      if (state == FULL) begin
        front_nxt       = ~front;
        front_valid_nxt = 1'b1;
        state_nxt       = FILL;
        swap_ack_nxt    = 1'b1;
      end else begin
        underrun_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      wcnt        <= '0;
      front       <= 1'b0;
      front_valid <= 1'b0;
      swap_ack    <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      front       <= front_nxt;
      front_valid <= front_valid_nxt;
      swap_ack    <= swap_ack_nxt;
      underrun    <= underrun_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{~front, wcnt}] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb1 <= '0;
      rgb2 <= '0;
    end else if (bus.rd_en) begin
      rgb1 <= front_valid ? plane_bits(up_px, bus.rd_plane) : '0;
      rgb2 <= front_valid ? plane_bits(lo_px, bus.rd_plane) : '0;
    end
  end
endmodule

// File: doc/hub75_linebuf.md
Name: hub75_linebuf

Overview:
- Double-buffered row-pair line buffer that sits directly upstream of the HUB75 output stage.
- Accepts a 24-bit RGB pixel stream for one row pair (upper half, then lower half) into a back bank.
- Serves the output stage's per-column, per-bitplane reads from the front bank as the 3-bit rgb1/rgb2 values.
- Bank swap happens on request from the scan logic at the row boundary.

Parameters:
- COLBITS, 6: log2 of columns per row; COLS = 2**COLBITS.
- BPC, 8: bits per colour channel; pixel width is 3*BPC.
- PLANEBITS, 3: width of the bitplane select; must satisfy 2**PLANEBITS >= BPC.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  buffer can accept a pixel.
- in_data  in  3*BPC  pixel {R,G,B}, each BPC bits, R in the MSBs.
- rd_en  in  1  read strobe from the output stage.
- rd_col  in  COLBITS  column to read.
- rd_plane  in  PLANEBITS  bitplane to read (0 = LSB).
- rgb1  out  3  {R,G,B} bit for the upper-half pixel.
- rgb2  out  3  {R,G,B} bit for the lower-half pixel.
- swap  in  1  single-cycle request to promote the back bank to front.
- swap_ack  out  1  pulse: swap performed.
- underrun  out  1  pulse: swap requested while back bank not full.
- front_valid  out  1  front bank holds a complete row pair.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Storage: 2 banks x 2 halves x COLS words of 3*BPC bits. A bank-select bit `front` chooses the read bank; the other bank is the back bank.
- Writer FSM, FILL state:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready writes in_data to back bank at half = wcnt[COLBITS], column = wcnt[COLBITS-1:0], then wcnt increments.
  - wcnt is COLBITS+1 bits, so the first COLS pixels go to the upper half and the next COLS to the lower half.
  - On the write with wcnt == 2*COLS-1, go to FULL and set wcnt to 0.
- Writer FSM, FULL state:
  - in_ready = 0; in_data is ignored.
- Swap handling:
  - swap while FULL: the next cycle has `front` toggled, front_valid = 1, writer in FILL, swap_ack = 1 for one cycle.
  - swap while FILL (including the same cycle as the final write): no bank change, underrun = 1 for one cycle. The final write still completes and the FSM enters FULL normally.
  - swap_ack and underrun are mutually exclusive and are never asserted without swap in the prior cycle.
- Read path, latency exactly 1 cycle:
  - On a cycle with rd_en = 1, the next cycle has rgb1 = {R[rd_plane], G[rd_plane], B[rd_plane]} of front bank upper half at rd_col; rgb2 is the same for the lower half.
  - rd_plane >= BPC yields 3'b000.
  - front_valid = 0 forces the read result to 3'b000.
  - With rd_en = 0, rgb1/rgb2 hold their previous values.
  - A read and a swap in the same cycle read the pre-swap front bank.
  - A write and a read in the same cycle never conflict, since they target different banks.
- Reset values: rgb1 = rgb2 = 0, swap_ack = underrun = 0, front_valid = 0, front = 0, writer FILL, wcnt = 0.
  - in_ready is 0 during the reset cycle and 1 from the first cycle after reset deasserts.
- Reset mid-fill discards the partial row pair; the next accepted pixel goes to upper half, column 0.
- Memory contents are not cleared by reset; front_valid gating guarantees zero output until the first swap.
- Throughput: one pixel per cycle while in FILL; one read per cycle.

Test Plan:
- After reset: front_valid = 0; rd_en at col 5, plane 0 -> rgb1 = rgb2 = 000 next cycle; in_ready = 1.
- Stream 128 pixels with pixel i = {i, ~i, 8'hA5} (COLBITS = 6, i truncated to 8 bits):
  - in_ready drops after pixel 127.
  - swap -> swap_ack next cycle, front_valid = 1.
  - Read col 3, plane 0 -> rgb1 = {1, 0, 1}, rgb2 (pixel 67 = {8'h43, 8'hBC, 8'hA5}) = {1, 0, 1}.
  - Plane 1 -> rgb1 = {1, 0, 0}.
- swap after only 10 pixels -> underrun pulse, no swap_ack, front_valid unchanged, in_ready stays 1. Finishing the remaining 118 pixels then swapping -> swap_ack.
- swap in the same cycle as the 128th write -> underrun. A swap on the next cycle -> swap_ack. Back bank refills while reads return the old front data unchanged.
- Reset asserted after 40 pixels:
  - After reset, 128 fresh pixels plus swap -> col 0 upper holds fresh pixel 0, not stale data.
  - front_valid was 0 until that swap.
- Randomised in_valid gaps plus continuous rd_en sweeping all cols and planes 0..7 over 3 swaps: every read matches the reference model with 1-cycle latency. rd_plane = 7 with BPC = 6 -> 000.
